// File: rtl/mips_mem_pkg.sv
// Shared store-path definitions for the MIPS data-memory write port.
// Used by store_lane_pack and store_narrow_unit (STORE_ALIGN_CHECK_EN aware).
package mips_mem_pkg;

    localparam int MEM_DATA_W = 16;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef logic [1:0] size_t;

    localparam size_t SIZE_BYTE = 2'b00;
    localparam size_t SIZE_HALF = 2'b01;
    localparam size_t SIZE_WORD = 2'b10;
    localparam size_t SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } store_state_t;

    // Word and reserved sizes both take two beats.
    function automatic logic is_word(input size_t s);
        return s[1];
    endfunction

    function automatic logic misaligned(input size_t s, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            s == SIZE_HALF: bad = a[0];
            s == SIZE_WORD: bad = (a != 2'b00);
            s == SIZE_RSVD: bad = 1'b1;
            default:        bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_pack.sv
// Combinational lane packer: places the stored bytes on the 16-bit port
// and yields byte enables plus the halfword offset within the word.
module store_lane_pack
    import mips_mem_pkg::*;
(
    input  size_t                 size_i,
    input  logic [1:0]            addr_i,
    input  logic [31:0]           data_i,
    input  logic                  beat_i,
    output logic [MEM_DATA_W-1:0] wdata_o,
    output logic [MEM_BE_W-1:0]   be_o,
    output logic [1:0]            off_o
);

    always_comb begin
        wdata_o = data_i[15:0];
        be_o    = 2'b11;
        off_o   = {addr_i[1], 1'b0};
        unique case (1'b1)
            size_i == SIZE_BYTE: begin
                wdata_o = {2{data_i[7:0]}};
                be_o    = addr_i[0] ? 2'b10 : 2'b01;
            end
            size_i == SIZE_HALF: begin
                off_o = {addr_i[1], 1'b0};
            end
            default: begin
                wdata_o = beat_i ? data_i[31:16] : data_i[15:0];
                off_o   = {beat_i, 1'b0};
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing FSM: splits SB/SH/SW into 16-bit write beats.
// Define STORE_ALIGN_CHECK_EN to reject misaligned/reserved stores via err.
module store_narrow_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_data,
    input  logic [1:0]            req_size,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    output logic [MEM_BE_W-1:0]   mem_be,
    output logic                  done,
    output logic                  err
);

    store_state_t          state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [31:0]           data_q;
    size_t                 size_q;

    logic                  mem_valid_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [MEM_DATA_W-1:0] mem_wdata_q;
    logic [MEM_BE_W-1:0]   mem_be_q;
    logic                  done_q;
    logic                  err_q;

    logic [MEM_DATA_W-1:0] lo_wdata;
    logic [MEM_BE_W-1:0]   lo_be;
    logic [1:0]            lo_off;
    logic [MEM_DATA_W-1:0] hi_wdata;
    logic [MEM_BE_W-1:0]   hi_be;
    logic [1:0]            hi_off;
    logic                  reject;

`ifdef STORE_ALIGN_CHECK_EN
    assign reject = misaligned(req_size, req_addr[1:0]);
`else
    assign reject = 1'b0;
`endif

    // First beat is packed straight from the request so it can
    // be registered on the handshake edge.
    store_lane_pack u_pack_lo (
        .size_i  (req_size),
        .addr_i  (req_addr[1:0]),
        .data_i  (req_data),
        .beat_i  (1'b0),
        .wdata_o (lo_wdata),
        .be_o    (lo_be),
        .off_o   (lo_off)
    );

    store_lane_pack u_pack_hi (
        .size_i  (size_q),
        .addr_i  (addr_q[1:0]),
        .data_i  (data_q),
        .beat_i  (1'b1),
        .wdata_o (hi_wdata),
        .be_o    (hi_be),
        .off_o   (hi_off)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            size_q      <= SIZE_BYTE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        data_q <= req_data;
                        size_q <= req_size;
                        if (reject) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= LO;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], lo_off};
                            mem_wdata_q <= lo_wdata;
                            mem_be_q    <= lo_be;
                        end
                    end
                end
                LO: begin
                    if (mem_ready) begin
                        if (is_word(size_q)) begin
                            state_q     <= HI;
                            mem_addr_q  <= {addr_q[ADDR_W-1:2], hi_off};
                            mem_wdata_q <= hi_wdata;
                            mem_be_q    <= hi_be;
                        end else begin
                            state_q     <= DONE;
                            mem_valid_q <= 1'b0;
                            mem_addr_q  <= '0;
                            mem_wdata_q <= '0;
                            mem_be_q    <= '0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (mem_ready) begin
                        state_q     <= DONE;
                        mem_valid_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '0;
                        done_q      <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
